// File: rtl/axi_seq_pkg.sv
// Shared definitions for the AXI command sequencer.
//   - seq_state_e : sequencer FSM states
//   - cmd_t       : one buffered host command (write flag plus AW/W/AR fields)
//   - BURST_*     : AXI burst type encodings
//   - sat_inc8    : saturating 8-bit increment used for the abort counter
package axi_seq_pkg;

  // Field widths of a buffered command; the sequencer's DATAWIDTH/SIZE defaults match these.
  localparam int unsigned CMD_DW = 32;
  localparam int unsigned CMD_SW = 3;

  localparam logic [CMD_SW-2:0] BURST_FIXED = 2'd0;
  localparam logic [CMD_SW-2:0] BURST_INCR  = 2'd1;
  localparam logic [CMD_SW-2:0] BURST_WRAP  = 2'd2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    WAIT  = 2'd2
  } seq_state_e;

  typedef struct packed {
    logic                  write;
    logic [CMD_DW-1:0]     addr;
    logic [CMD_DW/8-1:0]   id;
    logic [CMD_DW/8-1:0]   len;
    logic [CMD_SW-1:0]     size;
    logic [CMD_SW-2:0]     burst;
    logic [CMD_DW/8-1:0]   strb;
    logic [CMD_DW-1:0]     data;
  } cmd_t;

  // Increment that sticks at 8'hFF instead of wrapping back to zero.
  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    logic [7:0] r;
    if (v == 8'hFF) begin
      r = v;
    end else begin
      r = v + 8'd1;
    end
    return r;
  endfunction

endpackage

// File: rtl/axi_cmd_fifo.sv
// Synchronous FIFO of cmd_t entries.
// Ports: clk/rst_n (async active-low), push/push_data (write side),
//        pop/pop_data (read side, pop_data shows the head combinationally),
//        full, empty, count (entries held, 0..DEPTH).
// A push while full or a pop while empty is dropped. DEPTH must be a power of two.
module axi_cmd_fifo
  import axi_seq_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  cmd_t                     push_data,
  input  logic                     pop,
  output cmd_t                     pop_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned PW = $clog2(DEPTH);

  cmd_t          mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW:0]   count_q, count_d;
  logic          do_push_s, do_pop_s;

  assign full     = (count_q == (PW+1)'(DEPTH));
  assign empty    = (count_q == '0);
  assign count    = count_q;
  assign pop_data = mem_q[rd_ptr_q];

  // Next pointer/count values; pointers wrap naturally at the power-of-two depth.
  always_comb begin
    do_push_s = push && !full;
    do_pop_s  = pop && !empty;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q;
    if (do_push_s) begin
      wr_ptr_d = wr_ptr_q + PW'(1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (do_pop_s) begin
      rd_ptr_d = rd_ptr_q + PW'(1);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    case ({do_push_s, do_pop_s})
      2'b10:   count_d = count_q + (PW+1)'(1);
      2'b01:   count_d = count_q - (PW+1)'(1);
      default: count_d = count_q;
    endcase
  end

  // Pointer and occupancy registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Entry storage; cleared on reset so no stale command survives it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (do_push_s) begin
      mem_q[wr_ptr_q] <= push_data;
    end
  end

endmodule

// File: rtl/axi_cmd_sequencer.sv
// Command sequencer in front of an AXI3 master. Host commands are queued in a
// FIFO and issued one at a time: the head is popped onto the AW/W or AR output
// registers, a one-cycle wr_start/rd_start pulse follows, then the FSM waits for
// the matching wr_done/rd_done or aborts after TIMEOUT waiting cycles.
// Ports: clk/rst_n; cmd_* host push side with cmd_ready; AW*/W*/AR* command
// outputs; wr_start/rd_start pulses; wr_done/rd_done from the master;
// busy, fifo_count, timeout pulse and saturating err_count status.
module axi_cmd_sequencer
  import axi_seq_pkg::*;
#(
  parameter int unsigned DATAWIDTH = 32,
  parameter int unsigned SIZE      = 3,
  parameter int unsigned DEPTH     = 4,
  parameter int unsigned TIMEOUT   = 255
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     cmd_valid,
  output logic                     cmd_ready,
  input  logic                     cmd_write,
  input  logic [DATAWIDTH-1:0]     cmd_addr,
  input  logic [DATAWIDTH/8-1:0]   cmd_id,
  input  logic [DATAWIDTH/8-1:0]   cmd_len,
  input  logic [SIZE-1:0]          cmd_size,
  input  logic [SIZE-2:0]          cmd_burst,
  input  logic [DATAWIDTH/8-1:0]   cmd_strb,
  input  logic [DATAWIDTH-1:0]     cmd_data,
  output logic [DATAWIDTH-1:0]     AWaddr,
  output logic [DATAWIDTH/8-1:0]   AWlen,
  output logic [SIZE-1:0]          AWsize,
  output logic [SIZE-2:0]          AWburst,
  output logic [DATAWIDTH/8-1:0]   AWid,
  output logic [DATAWIDTH-1:0]     WData,
  output logic [DATAWIDTH/8-1:0]   WStrb,
  output logic [DATAWIDTH-1:0]     ARaddr,
  output logic [DATAWIDTH/8-1:0]   ARlen,
  output logic [SIZE-1:0]          ARsize,
  output logic [SIZE-2:0]          ARburst,
  output logic [DATAWIDTH/8-1:0]   ARid,
  output logic                     wr_start,
  output logic                     rd_start,
  input  logic                     wr_done,
  input  logic                     rd_done,
  output logic                     busy,
  output logic [$clog2(DEPTH):0]   fifo_count,
  output logic                     timeout,
  output logic [7:0]               err_count
);

  localparam int unsigned CW = $clog2(TIMEOUT + 1);

  seq_state_e  state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic        cur_write_q, cur_write_d;
  cmd_t        aw_q, aw_d;   // write command; only the write-side fields are driven out
  cmd_t        ar_q, ar_d;   // read command; only the read-side fields are driven out
  logic        wr_start_q, wr_start_d;
  logic        rd_start_q, rd_start_d;
  logic        timeout_q, timeout_d;
  logic        busy_q, busy_d;
  logic [7:0]  err_q, err_d;

  cmd_t        cmd_in_s;
  cmd_t        head_s;
  logic        fifo_full_s, fifo_empty_s, pop_s, done_s;

  // Pack the host command into the FIFO entry format.
  always_comb begin
    cmd_in_s       = '0;
    cmd_in_s.write = cmd_write;
    cmd_in_s.addr  = cmd_addr;
    cmd_in_s.id    = cmd_id;
    cmd_in_s.len   = cmd_len;
    cmd_in_s.size  = cmd_size;
    cmd_in_s.burst = cmd_burst;
    cmd_in_s.strb  = cmd_strb;
    cmd_in_s.data  = cmd_data;
  end

  axi_cmd_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (cmd_valid),
    .push_data (cmd_in_s),
    .pop       (pop_s),
    .pop_data  (head_s),
    .full      (fifo_full_s),
    .empty     (fifo_empty_s),
    .count     (fifo_count)
  );

  assign cmd_ready = !fifo_full_s;

  // FSM next state, output-register loads and abort bookkeeping.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    cur_write_d = cur_write_q;
    aw_d        = aw_q;
    ar_d        = ar_q;
    wr_start_d  = 1'b0;
    rd_start_d  = 1'b0;
    timeout_d   = 1'b0;
    err_d       = err_q;
    pop_s       = 1'b0;
    // Only the done that matches the in-flight command type counts.
    done_s      = cur_write_q ? wr_done : rd_done;
    case (state_q)
      IDLE: begin
        if (!fifo_empty_s) begin
          pop_s       = 1'b1;
          cur_write_d = head_s.write;
          if (head_s.write) begin
            aw_d       = head_s;
            wr_start_d = 1'b1;
          end else begin
            ar_d       = head_s;
            rd_start_d = 1'b1;
          end
          state_d = START;
        end else begin
          state_d = IDLE;
        end
      end
      START: begin
        cnt_d   = '0;
        state_d = WAIT;
      end
      WAIT: begin
        // Completion wins over abort when both land on the last waiting cycle.
        if (done_s) begin
          state_d = IDLE;
        end else if (cnt_q == CW'(TIMEOUT - 1)) begin
          timeout_d = 1'b1;
          err_d     = sat_inc8(err_q);
          state_d   = IDLE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    busy_d = (state_d != IDLE);
  end

  // State, counter and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      cur_write_q <= 1'b0;
      aw_q        <= '0;
      ar_q        <= '0;
      wr_start_q  <= 1'b0;
      rd_start_q  <= 1'b0;
      timeout_q   <= 1'b0;
      busy_q      <= 1'b0;
      err_q       <= 8'd0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      cur_write_q <= cur_write_d;
      aw_q        <= aw_d;
      ar_q        <= ar_d;
      wr_start_q  <= wr_start_d;
      rd_start_q  <= rd_start_d;
      timeout_q   <= timeout_d;
      busy_q      <= busy_d;
      err_q       <= err_d;
    end
  end

  assign AWaddr    = aw_q.addr;
  assign AWlen     = aw_q.len;
  assign AWsize    = aw_q.size;
  assign AWburst   = aw_q.burst;
  assign AWid      = aw_q.id;
  assign WData     = aw_q.data;
  assign WStrb     = aw_q.strb;
  assign ARaddr    = ar_q.addr;
  assign ARlen     = ar_q.len;
  assign ARsize    = ar_q.size;
  assign ARburst   = ar_q.burst;
  assign ARid      = ar_q.id;
  assign wr_start  = wr_start_q;
  assign rd_start  = rd_start_q;
  assign timeout   = timeout_q;
  assign busy      = busy_q;
  assign err_count = err_q;

endmodule
